// File: rtl/ps2_host.sv
// PS/2 host port: receiver, host-to-device transmitter and shared timeout timer.
// Optional receive FIFO is built when PS2_RXFIFO_EN is defined; without it,
// rx_valid is a one-cycle strobe and rx_rd is ignored.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | lines released, receiver active, transmitter can accept
// S_INHIBIT  | host holds clock low before request-to-send
// S_REQ      | host releases clock with data low (start bit), timer starts
// S_SEND     | drive d0..d7, parity on each device clock fall, then release
// S_ACK      | wait for the device's ack fall and sample data
// S_WAITIDLE | wait for both lines high, then report ack/nack
module ps2_host #(
   parameter int unsigned CLK_FREQ     = 0,      // system clock in Hz; every instance must override
   parameter int unsigned CLKWAIT_US   = 1,
   parameter int unsigned RX_TOUT_US   = 150,
   parameter int unsigned INHIBIT_US   = 100,
   parameter int unsigned TX_TOUT_US   = 15000,
   parameter int unsigned RXFIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_out,
   output logic       ps2_dat_out,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_rd,
   output logic       rx_error,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int unsigned CLKWAIT_TICKS = 32'((64'(CLKWAIT_US) * 64'(CLK_FREQ)) / 64'd1000000 + 64'd1);
   localparam int unsigned RX_TOUT_TICKS = 32'((64'(RX_TOUT_US) * 64'(CLK_FREQ)) / 64'd1000000 + 64'd1);
   localparam int unsigned INHIBIT_TICKS = 32'((64'(INHIBIT_US) * 64'(CLK_FREQ)) / 64'd1000000 + 64'd1);
   localparam int unsigned TX_TOUT_TICKS = 32'((64'(TX_TOUT_US) * 64'(CLK_FREQ)) / 64'd1000000 + 64'd1);

   localparam int unsigned MAX_A = (RX_TOUT_TICKS > INHIBIT_TICKS) ? RX_TOUT_TICKS : INHIBIT_TICKS;
   localparam int unsigned MAX_TICKS = (TX_TOUT_TICKS > MAX_A) ? TX_TOUT_TICKS : MAX_A;
   // +1 so the largest constant is representable even when it is a power of two
   localparam int TMR_W = $clog2(MAX_TICKS + 1);
   localparam int FRZ_W = $clog2(CLKWAIT_TICKS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SEND,
      S_ACK,
      S_WAITIDLE
   } state_e;

   state_e           state;
   logic [1:0]       clk_sync;
   logic [1:0]       dat_sync;
   logic             clk_d;
   logic             clk_s;
   logic             dat_s;
   logic [FRZ_W-1:0] freeze_cnt;
   logic             frozen;
   logic             fall;
   logic [TMR_W-1:0] timer;
   logic [3:0]       bit_cnt;
   logic [9:0]       rx_sr;
   logic [8:0]       tx_sr;
   logic             tx_ack;
   logic             rx_last;
   logic             frame_ok;
   logic             rx_good;
   logic             rx_bad;
   logic             rx_tout;
   logic             rx_ovf;
   logic             tx_tout;
   logic [7:0]       rx_byte;

   assign clk_s  = clk_sync[1];
   assign dat_s  = dat_sync[1];
   assign frozen = (freeze_cnt != '0);
   assign fall   = clk_d & ~clk_s & ~frozen;

   // rx_sr[0] is the start bit, [8:1] data, [9] parity; the stop bit is live dat_s
   assign rx_last  = fall && (state == S_IDLE) && (bit_cnt == 4'd10);
   assign frame_ok = ~rx_sr[0] & (^rx_sr[9:1]) & dat_s;
   assign rx_good  = rx_last & frame_ok;
   assign rx_bad   = rx_last & ~frame_ok;
   assign rx_byte  = rx_sr[8:1];
   assign rx_tout  = (state == S_IDLE) && !fall && (bit_cnt != 4'd0) &&
                     (timer == TMR_W'(RX_TOUT_TICKS));
   assign tx_tout  = ((state == S_REQ) || (state == S_SEND) || (state == S_ACK) ||
                      (state == S_WAITIDLE)) && (timer == TMR_W'(TX_TOUT_TICKS));

   assign tx_ready = (state == S_IDLE) && (bit_cnt == 4'd0) && !fall;

   // two-flop synchronisers for the pads plus a delayed clock for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_d    <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk_in};
         dat_sync <= {dat_sync[0], ps2_dat_in};
         clk_d    <= clk_s;
      end
   end

   // debounce: ignore further clock falls for a short window after each accepted one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freeze_cnt <= '0;
      end else if (fall) begin
         freeze_cnt <= FRZ_W'(CLKWAIT_TICKS);
      end else if (frozen) begin
         freeze_cnt <= freeze_cnt - FRZ_W'(1);
      end
   end

   // main controller: receiver in idle, transmit sequence, shared timer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         bit_cnt     <= 4'd0;
         timer       <= '0;
         rx_sr       <= '0;
         tx_sr       <= '0;
         tx_ack      <= 1'b0;
         ps2_clk_out <= 1'b1;
         ps2_dat_out <= 1'b1;
         rx_error    <= 1'b0;
         tx_done     <= 1'b0;
         tx_error    <= 1'b0;
      end else begin
         rx_error <= rx_bad | rx_tout | rx_ovf;
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         if (timer != '1)
            timer <= timer + TMR_W'(1);

         if (tx_tout) begin
            ps2_clk_out <= 1'b1;
            ps2_dat_out <= 1'b1;
            tx_error    <= 1'b1;
            bit_cnt     <= 4'd0;
            state       <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (fall) begin
                     timer <= '0;
                     rx_sr <= {dat_s, rx_sr[9:1]};
                     if (bit_cnt == 4'd10)
                        bit_cnt <= 4'd0;
                     else
                        bit_cnt <= bit_cnt + 4'd1;
                  end else if (rx_tout) begin
                     bit_cnt <= 4'd0;
                  end else if (tx_valid && tx_ready) begin
                     tx_sr       <= {~^tx_data, tx_data};
                     timer       <= '0;
                     ps2_clk_out <= 1'b0;
                     ps2_dat_out <= 1'b1;
                     state       <= S_INHIBIT;
                  end
               end
               S_INHIBIT: begin
                  if (timer == TMR_W'(INHIBIT_TICKS - 1)) begin
                     ps2_clk_out <= 1'b1;
                     ps2_dat_out <= 1'b0;
                     timer       <= '0;
                     state       <= S_REQ;
                  end
               end
               S_REQ: begin
                  bit_cnt <= 4'd0;
                  state   <= S_SEND;
               end
               S_SEND: begin
                  if (fall) begin
                     if (bit_cnt == 4'd9) begin
                        ps2_dat_out <= 1'b1;
                        bit_cnt     <= 4'd0;
                        state       <= S_ACK;
                     end else begin
                        ps2_dat_out <= tx_sr[0];
                        tx_sr       <= {1'b1, tx_sr[8:1]};
                        bit_cnt     <= bit_cnt + 4'd1;
                     end
                  end
               end
               S_ACK: begin
                  if (fall) begin
                     tx_ack <= ~dat_s;
                     state  <= S_WAITIDLE;
                  end
               end
               S_WAITIDLE: begin
                  if (clk_s && dat_s) begin
                     tx_done  <= tx_ack;
                     tx_error <= ~tx_ack;
                     bit_cnt  <= 4'd0;
                     state    <= S_IDLE;
                  end
               end
               default: begin
                  ps2_clk_out <= 1'b1;
                  ps2_dat_out <= 1'b1;
                  bit_cnt     <= 4'd0;
                  state       <= S_IDLE;
               end
            endcase
         end
      end
   end

`ifdef PS2_RXFIFO_EN
   localparam int PTR_W = $clog2(RXFIFO_DEPTH);

   logic [7:0]       fifo_mem [RXFIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;

   assign empty    = (count == '0);
   assign full     = (count == (PTR_W+1)'(RXFIFO_DEPTH));
   assign pop      = rx_rd && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO still keeps the byte
   assign push     = rx_good && (!full || pop);
   assign rx_ovf   = rx_good && full && !pop;
   assign rx_valid = !empty;
   assign rx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

   // FIFO storage, no reset needed on the data array
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= rx_byte;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + (PTR_W+1)'(1);
         else if (pop && !push)
            count <= count - (PTR_W+1)'(1);
      end
   end
`else
   logic unused_rx_rd;

   assign rx_ovf       = 1'b0;
   assign unused_rx_rd = rx_rd;

   // single-byte output register with a one-cycle valid strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid <= 1'b0;
         rx_data  <= 8'h00;
      end else begin
         rx_valid <= rx_good;
         if (rx_good)
            rx_data <= rx_byte;
      end
   end
`endif

endmodule

// File: tb/tb_ps2_host.sv
`timescale 1ns/1ps
module tb_ps2_host;

   localparam int US = 1000;

   logic       clk;
   logic       rst_n;
   logic       dev_clk;
   logic       dev_dat;
   logic       ps2_clk_line;
   logic       ps2_dat_line;
   logic       ps2_clk_out;
   logic       ps2_dat_out;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_rd;
   logic       rx_error;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  rxv_cnt = 0;
   int  rxe_cnt = 0;
   int  txd_cnt = 0;
   int  txe_cnt = 0;
   logic [7:0] rx_last = 8'h00;
   time t_last_fall = 0;
   time rxe_time = 0;
   time txe_time = 0;

   // open-drain wired-AND of device and host
   assign ps2_clk_line = dev_clk & ps2_clk_out;
   assign ps2_dat_line = dev_dat & ps2_dat_out;

   ps2_host #(.CLK_FREQ(1_000_000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ps2_clk_in  (ps2_clk_line),
      .ps2_dat_in  (ps2_dat_line),
      .ps2_clk_out (ps2_clk_out),
      .ps2_dat_out (ps2_dat_out),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_rd       (rx_rd),
      .rx_error    (rx_error),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_error    (tx_error)
   );

   initial clk = 1'b0;
   always #500 clk = ~clk;

   // pulse counters sampled away from the active edge
   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_cnt++;
         rx_last = rx_data;
      end
      if (rx_error) begin
         rxe_cnt++;
         rxe_time = $time;
      end
      if (tx_done)
         txd_cnt++;
      if (tx_error) begin
         txe_cnt++;
         txe_time = $time;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_counts();
      rxv_cnt = 0;
      rxe_cnt = 0;
      txd_cnt = 0;
      txe_cnt = 0;
   endtask

   // device-to-host frame: first nbits of {stop, parity, data, start}, 12.5 kHz
   task automatic dev_send(input logic [7:0] b, input logic par, input int nbits);
      logic [10:0] frame;
      frame = {1'b1, par, b, 1'b0};
      @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         dev_dat = frame[i];
         #(20*US);
         dev_clk = 1'b0;
         t_last_fall = $time;
         #(40*US);
         dev_clk = 1'b1;
         #(20*US);
      end
      dev_dat = 1'b1;
   endtask

   // device clocks in 10 host bits (sampled on rising clock), then ACKs
   task automatic dev_recv(output logic [9:0] bits);
      bits = '0;
      for (int i = 0; i < 10; i++) begin
         #(20*US);
         dev_clk = 1'b0;
         #(40*US);
         bits[i] = ps2_dat_line;
         dev_clk = 1'b1;
      end
      #(10*US);
      dev_dat = 1'b0;
      #(10*US);
      dev_clk = 1'b0;
      #(40*US);
      dev_clk = 1'b1;
      #(20*US);
      dev_dat = 1'b1;
   endtask

   task automatic host_send(input logic [7:0] b);
      @(negedge clk);
      check("tx_ready_before", {31'd0, tx_ready}, 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic expect_rx(input string tag, input logic [7:0] b);
`ifdef PS2_RXFIFO_EN
      @(negedge clk);
      check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, rx_data}, {24'd0, b});
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
      check({tag, "_popped"}, {31'd0, rx_valid}, 32'd0);
`else
      check({tag, "_valid_cnt"}, rxv_cnt, 32'd1);
      check({tag, "_data"}, {24'd0, rx_last}, {24'd0, b});
`endif
   endtask

   task automatic expect_no_rx(input string tag);
`ifdef PS2_RXFIFO_EN
      check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
`else
      check({tag, "_valid_cnt"}, rxv_cnt, 32'd0);
`endif
   endtask

   initial begin
      #(100_000*US);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] bits;
      int         n_low;
      int         n_wait;
      time        t_req;
      time        dt;

      rst_n    = 1'b0;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      rx_rd    = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_clk_out",  {31'd0, ps2_clk_out}, 32'd1);
      check("rst_dat_out",  {31'd0, ps2_dat_out}, 32'd1);
      check("rst_rx_data",  {24'd0, rx_data}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_rx_error", {31'd0, rx_error}, 32'd0);
      check("rst_tx_done",  {31'd0, tx_done}, 32'd0);
      check("rst_tx_error", {31'd0, tx_error}, 32'd0);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);

      // good 0x1C frame
      clr_counts();
      dev_send(8'h1C, 1'b0, 11);
      repeat (10) @(negedge clk);
      expect_rx("rx_1c", 8'h1C);
      check("rx_1c_err_cnt", rxe_cnt, 32'd0);

      // same frame, wrong parity
      #(100*US);
      clr_counts();
      dev_send(8'h1C, 1'b1, 11);
      repeat (10) @(negedge clk);
      check("rx_par_err_cnt", rxe_cnt, 32'd1);
      expect_no_rx("rx_par");

      // 4 bits then idle: abort about 150 us after the last fall
      #(100*US);
      clr_counts();
      dev_send(8'hAA, 1'b1, 4);
      #(200*US);
      check("rx_tout_err_cnt", rxe_cnt, 32'd1);
      dt = rxe_time - t_last_fall;
      check("rx_tout_time", {31'd0, (dt >= 150*US) && (dt <= 158*US)}, 32'd1);
      expect_no_rx("rx_tout");
      clr_counts();
      dev_send(8'hAA, 1'b1, 11);
      repeat (10) @(negedge clk);
      expect_rx("rx_aa", 8'hAA);
      check("rx_aa_err_cnt", rxe_cnt, 32'd0);

      // host sends 0xED, device ACKs
      #(100*US);
      clr_counts();
      host_send(8'hED);
      @(negedge clk);
      check("inhibit_dat", {31'd0, ps2_dat_out}, 32'd1);
      n_low = 0;
      while (ps2_clk_out == 1'b0 && n_low < 300) begin
         n_low++;
         @(negedge clk);
      end
      check("inhibit_len", n_low, 32'd101);
      check("req_dat_low", {31'd0, ps2_dat_out}, 32'd0);
      dev_recv(bits);
      check("tx_ed_data",   {24'd0, bits[7:0]}, 32'h0000_00ED);
      check("tx_ed_parity", {31'd0, bits[8]}, 32'd1);
      check("tx_ed_stop",   {31'd0, bits[9]}, 32'd1);
      repeat (20) @(negedge clk);
      check("tx_ed_done_cnt", txd_cnt, 32'd1);
      check("tx_ed_err_cnt",  txe_cnt, 32'd0);
      check("tx_ed_ready",    {31'd0, tx_ready}, 32'd1);
      check("tx_ed_lines",    {30'd0, ps2_clk_out, ps2_dat_out}, 32'd3);

      // host sends 0xF4, device never clocks
      #(100*US);
      clr_counts();
      host_send(8'hF4);
      n_wait = 0;
      while (ps2_dat_out == 1'b1 && n_wait < 300) begin
         n_wait++;
         @(negedge clk);
      end
      t_req = $time;
      n_wait = 0;
      while (txe_cnt == 0 && n_wait < 16_000) begin
         n_wait++;
         @(negedge clk);
      end
      check("tx_tout_err_cnt", txe_cnt, 32'd1);
      check("tx_tout_done_cnt", txd_cnt, 32'd0);
      dt = txe_time - t_req;
      check("tx_tout_time", {31'd0, (dt >= 15_000*US) && (dt <= 15_004*US)}, 32'd1);
      @(negedge clk);
      check("tx_tout_lines", {30'd0, ps2_clk_out, ps2_dat_out}, 32'd3);
      check("tx_tout_ready", {31'd0, tx_ready}, 32'd1);

`ifdef PS2_RXFIFO_EN
      // five bytes into a depth-4 FIFO without popping
      begin
         logic [7:0] exp_b [5];
         exp_b[0] = 8'h11;
         exp_b[1] = 8'h22;
         exp_b[2] = 8'h33;
         exp_b[3] = 8'h44;
         exp_b[4] = 8'h55;
         #(100*US);
         clr_counts();
         for (int i = 0; i < 5; i++) begin
            dev_send(exp_b[i], 1'b1, 11);
            #(40*US);
         end
         repeat (10) @(negedge clk);
         check("fifo_ovf_err_cnt", rxe_cnt, 32'd1);
         for (int i = 0; i < 4; i++) begin
            check("fifo_pop_valid", {31'd0, rx_valid}, 32'd1);
            check("fifo_pop_data", {24'd0, rx_data}, {24'd0, exp_b[i]});
            rx_rd = 1'b1;
            @(negedge clk);
            rx_rd = 1'b0;
         end
         check("fifo_empty", {31'd0, rx_valid}, 32'd0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_host.md
Name: ps2_host

Overview:
- PS/2 host port: full-duplex successor to the receive-only PS/2 block. Adds a host-to-device transmitter and a parametrised timing set.
- Adds an optional receive FIFO.
- Sits between the open-drain PS/2 pad pair (clk/dat in, out-low-enables) and the keyboard/mouse scan logic.
- Used for LED/typematic commands and mouse init.

Parameters:
- CLK_FREQ, none (must be set), system clock in Hz.
- CLKWAIT_US, 1, debounce freeze after each accepted PS/2 clock fall.
- RX_TOUT_US, 150, max gap between bits of a frame before abort; must exceed CLKWAIT_US.
- INHIBIT_US, 100, host clock-low time before request-to-send.
- TX_TOUT_US, 15000, max time from request-to-send to end of ACK.
- RXFIFO_DEPTH, 4, entries, power of 2, >=2; used only with PS2_RXFIFO_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk_in  in  1  PS/2 clock pad input (async)
- ps2_dat_in  in  1  PS/2 data pad input (async)
- ps2_clk_out  out  1  0 = drive clock low, 1 = release
- ps2_dat_out  out  1  0 = drive data low, 1 = release
- rx_data  out  8  received byte
- rx_valid  out  1  received byte present
- rx_rd  in  1  pop strobe (FIFO mode only, else ignored)
- rx_error  out  1  1-cycle pulse on a bad or aborted rx frame
- tx_data  in  8  byte to send
- tx_valid  in  1  send request
- tx_ready  out  1  transmitter can accept
- tx_done  out  1  1-cycle pulse, device ACKed
- tx_error  out  1  1-cycle pulse, no ACK or timeout

Behaviour:
- Tick constants: X_TICKS = int(X_US*CLK_FREQ/1e6)+1. A single shared timer is sized $clog2 of the largest tick constant.
- Reset values: ps2_clk_out=1, ps2_dat_out=1, rx_data=0, rx_valid=0, rx_error=0, tx_done=0, tx_error=0, state=IDLE, FIFO empty.
- Input sampling: both pads pass through 2-flop synchronisers.
  - fall = synced clk 1->0 while not frozen.
  - freeze sets on fall and clears CLKWAIT_TICKS after it.
- RX: active in state IDLE only.
  - Frame: start 0, d0..d7 LSB first, odd parity, stop 1. Data is sampled on each fall.
  - The 11th fall is checked: start==0, parity odd, stop==1.
    - Pass: rx_data updates and rx_valid pulses 1 cycle (non-FIFO) on the cycle after the 11th fall.
    - Fail: rx_error pulses instead.
  - Timer restarts on every fall. With bit_cnt!=0 and timer==RX_TOUT_TICKS: rx_error pulses and bit_cnt clears.
- tx_ready = (state==IDLE) && (bit_cnt==0) && !fall. It is combinational and reads 1 when idle.
- TX accept: tx_valid && tx_ready. Latch the byte and compute odd parity. If rx starts on the same cycle, tx_ready is 0 and RX wins.
- TX states:
  - INHIBIT: clk_out=0, dat_out=1 for INHIBIT_TICKS, then REQ.
  - REQ: dat_out=0, clk_out=1. Start TX_TOUT timer, then SEND. The start bit is this low.
  - SEND: on each fall, drive the next bit: d0..d7, parity, then release (stop=1). After the fall that releases stop, go to ACK.
  - ACK: at the next fall, sample synced dat. 0 means ACK; 1 means NACK.
  - WAITIDLE: wait for synced clk=1 and dat=1, then IDLE. Pulse tx_done (ACK) or tx_error (NACK) on entry to IDLE.
  - Timer reaching TX_TOUT_TICKS in any of REQ..WAITIDLE: release both lines, pulse tx_error, go to IDLE, clear bit_cnt.
- The receiver ignores falls while state!=IDLE.
- Reset mid-frame: lines are released immediately (async) and no done/error pulse is issued.

Optional Feature:
- PS2_RXFIFO_EN defined: good bytes are pushed into an RXFIFO_DEPTH FIFO.
  - rx_valid = !empty (level), rx_data = head.
  - rx_rd && rx_valid pops.
  - Push while full drops the new byte and pulses rx_error.
  - Push and pop in the same cycle while full: pop first, byte is kept.
- Undefined: no FIFO. rx_valid is the 1-cycle pulse and rx_rd is ignored.

Test Plan:
- Device sends 0x1C (parity 0, stop 1) at 12.5 kHz -> one rx_valid pulse, rx_data=0x1C, no rx_error.
- Same frame with parity bit 1 -> rx_error pulse, rx_valid stays 0.
- 4 bits of a frame, then clock idle 200 us -> rx_error once at 150 us after the last fall; a following good 0xAA is received correctly.
- tx_data=0xED: clk low 100 us, then data low. Model clocks, samples bits 1,0,1,1,0,1,1,1 with parity 1, stop 1, ACK 0 -> tx_done pulse, tx_ready returns to 1.
- tx_data=0xF4, model never clocks -> tx_error at 15 ms, both outputs 1.
- FIFO mode, depth 4: send 5 bytes with no rx_rd -> 5th dropped with rx_error; pops return bytes 1..4 in order, then rx_valid=0.
